// File: rtl/eeg_pkg.sv
// Shared constants and issue-FSM state encoding for the EEG frame loader.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package eeg_pkg;
    localparam int FRAME_LEN  = 8;
    localparam int DATA_W_DEF = 8;
    localparam int PTR_W      = $clog2(FRAME_LEN);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_LOAD   = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_WAIT   = ST_WAIT,
        S_LOAD   = ST_LOAD,
        S_DRAIN  = ST_DRAIN
    } issue_state_t;
endpackage

// File: rtl/eeg_frame_loader_if.sv
// Sample stream in, parallel frame and DCT/buffer sequencing out.
// Latency: n/a (wiring only).
// Backpressure: s_ready gates s_valid; the frame side has none.
interface eeg_frame_loader_if
    import eeg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                     s_valid;
    logic signed [DATA_W-1:0] s_data;
    logic                     s_ready;
    logic                     flush;
    logic signed [DATA_W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic                     dct_en;
    logic                     dct_cs;
    logic                     buf_en;
    logic                     busy;
    logic [15:0]              frame_cnt;

    modport master (
        output s_valid, s_data, flush,
        input  s_ready, out0, out1, out2, out3, out4, out5, out6, out7,
        input  dct_en, dct_cs, buf_en, busy, frame_cnt
    );

    modport slave (
        input  s_valid, s_data, flush,
        output s_ready, out0, out1, out2, out3, out4, out5, out6, out7,
        output dct_en, dct_cs, buf_en, busy, frame_cnt
    );
endinterface

// File: rtl/eeg_frame_bank.sv
// One 8-sample frame store: indexed write, zero-pad from an index, parallel read.
// Latency: writes visible on rd the cycle after the edge.
// Backpressure: none; the caller only writes a bank that is not full.
module eeg_frame_bank
    import eeg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [PTR_W-1:0]                    widx,
    input  logic [DATA_W-1:0]                   wdata,
    input  logic                                pad,
    input  logic [PTR_W:0]                      pad_from,
    output logic [FRAME_LEN-1:0][DATA_W-1:0]    rd
);
    logic [FRAME_LEN-1:0][DATA_W-1:0] mem;

    // The written slot wins over padding so a sample arriving with flush is kept.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (we && (widx == PTR_W'(i))) begin
                mem[i] <= wdata;
            end else if (pad && ((PTR_W+1)'(i) >= pad_from)) begin
                mem[i] <= '0;
            end
        end
    end

    assign rd = mem;
endmodule

// File: rtl/eeg_frame_loader.sv
// Packs serial EEG samples into ping-pong 8-sample frames and sequences DCT/buffer.
// Latency: 8th accept at t -> dct_en at t+2; one frame per 3+DCT_LAT+DRAIN_CYC cycles.
// Backpressure: s_ready drops (registered) while both banks hold unissued frames.
module eeg_frame_loader
    import eeg_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DCT_LAT   = 4,
    parameter int DRAIN_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    eeg_frame_loader_if.slave   bus
);
    localparam int CNT_W = 8;

    issue_state_t                       state_q, state_d;
    logic [CNT_W-1:0]                   cnt_q;
    logic [PTR_W-1:0]                   wr_ptr;
    logic                               fill_bank, issue_bank;
    logic [1:0]                         full_q, full_d;
    logic                               s_ready_q;
    logic [15:0]                        frame_cnt_q;
    logic [FRAME_LEN-1:0][DATA_W-1:0]   rd0, rd1, out_q;
    logic                               accept, last, do_flush, close, drain_done;
    logic                               dct_en, dct_cs, buf_en;
    logic [1:0]                         we, pad;
    logic [PTR_W:0]                     pad_from;

    assign accept     = bus.s_valid && s_ready_q;
    assign last       = accept && (wr_ptr == PTR_W'(FRAME_LEN-1));
    assign do_flush   = bus.flush && !last && (accept || (wr_ptr != '0));
    assign close      = last || do_flush;
    assign drain_done = (state_q == S_DRAIN) && (cnt_q == CNT_W'(DRAIN_CYC-1));
    assign pad_from   = accept ? ({1'b0, wr_ptr} + (PTR_W+1)'(1)) : {1'b0, wr_ptr};

    always_comb begin
        we  = '0;
        pad = '0;
        we[fill_bank]  = accept;
        pad[fill_bank] = do_flush;
    end

    eeg_frame_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk(clk), .we(we[0]), .widx(wr_ptr), .wdata(bus.s_data),
        .pad(pad[0]), .pad_from(pad_from), .rd(rd0)
    );

    eeg_frame_bank #(.DATA_W(DATA_W)) u_bank1 (
        .clk(clk), .we(we[1]), .widx(wr_ptr), .wdata(bus.s_data),
        .pad(pad[1]), .pad_from(pad_from), .rd(rd1)
    );

    // Drain always targets the issue bank and close the fill bank; they never coincide.
    always_comb begin
        full_d = full_q;
        if (drain_done) full_d[issue_bank] = 1'b0;
        if (close)      full_d[fill_bank]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            fill_bank   <= 1'b0;
            issue_bank  <= 1'b0;
            full_q      <= '0;
            s_ready_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (close) begin
                wr_ptr <= '0;
            end else if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            fill_bank <= fill_bank ^ close;
            if (drain_done) begin
                issue_bank  <= ~issue_bank;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            full_q    <= full_d;
            s_ready_q <= !full_d[fill_bank ^ close];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
            if ((state_q == S_IDLE) && (state_d == S_LAUNCH)) begin
                out_q <= issue_bank ? rd1 : rd0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dct_en  = 1'b0;
        dct_cs  = 1'b0;
        buf_en  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_q[issue_bank]) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                dct_en  = 1'b1;
                dct_cs  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                dct_cs = 1'b1;
                if (cnt_q == CNT_W'(DCT_LAT-1)) state_d = S_LOAD;
            end
            S_LOAD: begin
                buf_en  = 1'b1;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                buf_en = 1'b1;
                if (drain_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.dct_en    = dct_en;
    assign bus.dct_cs    = dct_cs;
    assign bus.buf_en    = buf_en;
    assign bus.busy      = (state_q != S_IDLE) || (|full_q);
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.out0      = out_q[0];
    assign bus.out1      = out_q[1];
    assign bus.out2      = out_q[2];
    assign bus.out3      = out_q[3];
    assign bus.out4      = out_q[4];
    assign bus.out5      = out_q[5];
    assign bus.out6      = out_q[6];
    assign bus.out7      = out_q[7];
endmodule

// File: tb/tb_eeg_frame_loader.sv
// Bench for eeg_frame_loader: directed cases plus random traffic against a frame-queue model.
// Latency: n/a.
// Backpressure: driver holds s_valid until the sample is taken.
module tb_eeg_frame_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eeg_frame_loader_if #(.DATA_W(8)) bus ();

    eeg_frame_loader dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [63:0] frm;
        int          close_cyc;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  cur[$];
    logic [63:0] live_frm;
    logic [15:0] frames_done;
    int          cyc, closed, drained, last_launch, buf_run, cs_run;
    int          n_cmp, n_err;
    logic        acc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] outs();
        return {bus.out7, bus.out6, bus.out5, bus.out4, bus.out3, bus.out2, bus.out1, bus.out0};
    endfunction

    task automatic model_reset();
        cur.delete();
        expq.delete();
        closed      = 0;
        drained     = 0;
        frames_done = '0;
        last_launch = -1000;
        buf_run     = 0;
        cs_run      = 0;
    endtask

    task automatic close_frame(input int c);
        exp_t e;
        e.frm = '0;
        for (int i = 0; i < cur.size(); i++) e.frm[8*i +: 8] = cur[i];
        e.close_cyc = c;
        expq.push_back(e);
        cur.delete();
        closed++;
    endtask

    task automatic monitor(input logic was_rst);
        exp_t e;
        int   exp_l;
        if (was_rst) begin
            check_val("rst_ctrl", {bus.dct_en, bus.dct_cs, bus.buf_en, bus.busy, bus.s_ready}, 0);
            check_val("rst_frame_cnt", bus.frame_cnt, 0);
            check_val("rst_outs", outs(), 0);
            return;
        end
        if (bus.buf_en) begin
            buf_run++;
        end else if (buf_run > 0) begin
            check_val("buf_en_len", buf_run, 9);
            buf_run = 0;
            drained++;
            frames_done = frames_done + 16'd1;
            check_val("frame_cnt", bus.frame_cnt, frames_done);
        end
        if (bus.dct_cs) begin
            cs_run++;
        end else if (cs_run > 0) begin
            check_val("dct_cs_len", cs_run, 5);
            cs_run = 0;
        end
        if (bus.dct_en) begin
            if (expq.size() == 0) begin
                check_val("spurious_launch", bus.dct_en, 0);
            end else begin
                e        = expq.pop_front();
                live_frm = e.frm;
                check_val("frame_data", outs(), e.frm);
                exp_l = e.close_cyc + 2;
                if (last_launch + 15 > exp_l) exp_l = last_launch + 15;
                check_val("launch_cyc", cyc, exp_l);
                last_launch = cyc;
            end
        end else if (bus.dct_cs) begin
            check_val("out_hold", outs(), live_frm);
        end
        check_val("s_ready", bus.s_ready, (closed - drained) < 2);
        check_val("busy", bus.busy, (closed - drained) > 0);
    endtask

    // Called at a negedge: drive this cycle's inputs, cross one clock edge, update model, check.
    task automatic cycle(input logic v, input logic [7:0] d, input logic f, output logic accepted);
        logic was_rst;
        int   c;
        bus.s_valid = v;
        bus.s_data  = d;
        bus.flush   = f;
        accepted    = v && bus.s_ready;
        was_rst     = rst;
        c           = cyc;
        @(negedge clk);
        cyc++;
        if (was_rst) begin
            model_reset();
        end else begin
            if (accepted && !rst) cur.push_back(d);
            if (cur.size() == 8) close_frame(c);
            else if (f && cur.size() > 0) close_frame(c);
        end
        monitor(was_rst);
    endtask

    task automatic send(input logic [7:0] d, input logic f);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 100 && !a; i++) cycle(1'b1, d, f, a);
        if (!a) check_val("send_timeout", bus.s_ready, 1);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic wait_idle();
        logic a;
        int   i;
        for (i = 0; i < 200 && (bus.busy || expq.size() > 0); i++) cycle(1'b0, 8'h00, 1'b0, a);
        if (i == 200) check_val("idle_timeout", bus.busy, 0);
        idle(2);
    endtask

    initial begin
        int i;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.flush   = 1'b0;
        cyc         = 0;
        n_cmp       = 0;
        n_err       = 0;
        live_frm    = '0;
        model_reset();
        @(negedge clk);
        cycle(1'b0, 8'h00, 1'b0, acc);
        cycle(1'b0, 8'h00, 1'b0, acc);
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, acc);
        check_val("ready_after_rst", bus.s_ready, 1);

        // 1: one frame 1..8
        for (int k = 1; k <= 8; k++) send(8'(k), 1'b0);
        wait_idle();
        check_val("t1_frame_cnt", bus.frame_cnt, 1);
        check_val("t1_out_hold", outs(), 64'h0807060504030201);

        // 2: 24 samples with s_valid held high
        for (int k = 0; k < 24; k++) send(8'(8'h40 + k), 1'b0);
        wait_idle();
        check_val("t2_frame_cnt", bus.frame_cnt, 4);

        // 3: short record closed by flush
        send(8'hFB, 1'b0);
        send(8'h7F, 1'b0);
        send(8'h80, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, acc);
        wait_idle();
        check_val("t3_pad", outs(), 64'h0000_0000_0080_7FFB);

        // 4: flush on the 8th sample, then flush with an empty bank
        for (int k = 0; k < 7; k++) send(8'(8'h90 + k), 1'b0);
        send(8'h97, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, acc);
        wait_idle();
        check_val("t4_one_frame", bus.frame_cnt, 6);

        // 5: reset during WAIT with the other bank half full
        for (int k = 0; k < 8; k++) send(8'(8'hA0 + k), 1'b0);
        for (int k = 0; k < 4; k++) send(8'(8'hB0 + k), 1'b0);
        for (i = 0; i < 50 && !(bus.dct_cs && !bus.dct_en); i++) cycle(1'b0, 8'h00, 1'b0, acc);
        check_val("t5_in_wait", bus.dct_cs, 1);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, acc);
        rst = 1'b0;
        cycle(1'b0, 8'h00, 1'b0, acc);
        for (int k = 0; k < 8; k++) send(8'(8'hC0 + k), 1'b0);
        wait_idle();
        check_val("t5_clean_frame", bus.frame_cnt, 1);

        // 6: random traffic with occasional flushes
        for (int k = 0; k < 600; k++) begin
            logic v, f;
            v = ($urandom_range(0, 9) < 7);
            f = !v && ($urandom_range(0, 24) == 0);
            cycle(v, 8'($urandom), f, acc);
        end
        cycle(1'b0, 8'h00, 1'b1, acc);
        wait_idle();
        check_val("t6_left_frames", expq.size(), 0);

        // 7: frame counter wrap
        force dut.frame_cnt_q = 16'hFFFE;
        frames_done = 16'hFFFE;
        cycle(1'b0, 8'h00, 1'b0, acc);
        release dut.frame_cnt_q;
        for (int k = 0; k < 16; k++) send(8'($urandom), 1'b0);
        wait_idle();
        check_val("t7_wrap", bus.frame_cnt, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
